// File: rtl/alarm_pkg.sv
// Shared definitions for the time editor: FSM states, BCD digit limits and field offsets,
// plus the single-digit step helper used by the editor datapath.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [3:0] MIN_UNITS_MAX    = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX     = 4'd5;
    localparam logic [3:0] HR_TENS_MAX      = 4'd2;
    localparam logic [3:0] HR_UNITS_MAX_20S = 4'd3;

    localparam int MIN_UNITS_LSB = 0;
    localparam int MIN_TENS_LSB  = 4;
    localparam int HR_UNITS_LSB  = 8;
    localparam int HR_TENS_LSB   = 12;

    function automatic logic [3:0] wrap_step(input logic [3:0] d,
                                             input logic [3:0] max_v,
                                             input logic       inc);
        if (inc)
            return (d >= max_v) ? 4'd0 : d + 4'd1;
        else
            return (d == 4'd0) ? max_v : d - 4'd1;
    endfunction

    // Steps one digit (idx 0..3 = min units .. hr tens); moving hr tens onto 2 clamps hr units to 3.
    function automatic logic [15:0] step_time(input logic [15:0] t,
                                              input logic [1:0]  idx,
                                              input logic        inc);
        logic [3:0]  mu;
        logic [3:0]  mt;
        logic [3:0]  hu;
        logic [3:0]  ht;
        logic [3:0]  hu_max;
        logic [15:0] r;
        mu     = t[MIN_UNITS_LSB +: 4];
        mt     = t[MIN_TENS_LSB  +: 4];
        hu     = t[HR_UNITS_LSB  +: 4];
        ht     = t[HR_TENS_LSB   +: 4];
        hu_max = (ht == HR_TENS_MAX) ? HR_UNITS_MAX_20S : MIN_UNITS_MAX;
        case (idx)
            2'd0: mu = wrap_step(mu, MIN_UNITS_MAX, inc);
            2'd1: mt = wrap_step(mt, MIN_TENS_MAX, inc);
            2'd2: hu = wrap_step(hu, hu_max, inc);
            default: begin
                ht = wrap_step(ht, HR_TENS_MAX, inc);
                if (ht == HR_TENS_MAX && hu > HR_UNITS_MAX_20S)
                    hu = HR_UNITS_MAX_20S;
            end
        endcase
        r = '0;
        r[MIN_UNITS_LSB +: 4] = mu;
        r[MIN_TENS_LSB  +: 4] = mt;
        r[HR_UNITS_LSB  +: 4] = hu;
        r[HR_TENS_LSB   +: 4] = ht;
        return r;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector: registers the previous button level and flags a low-to-high change.
module btn_edge (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            prev_q <= 1'b0;
        else
            prev_q <= btn;
    end

    assign rise = btn & ~prev_q;

endmodule

// File: rtl/time_editor.sv
// Clock-time editor: captures time_in, lets up/down buttons step one BCD digit, then pulses commit.
// Define TIME_EDITOR_AUTOREPEAT_EN to add hold-to-repeat stepping (REPEAT_DELAY / REPEAT_RATE).
module time_editor
    import alarm_pkg::*;
#(
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        active,
    input  logic [7:0]  sel,
    input  logic        up,
    input  logic        down,
    input  logic [15:0] time_in,
    output logic [15:0] edit_time,
    output logic        editing,
    output logic        commit
);

    state_e      state_q, state_d;
    logic [15:0] edit_q, edit_d;
    logic        up_rise, dn_rise;
    logic        up_rpt, dn_rpt;
    logic        up_req, dn_req;
    logic        sel_ok;
    logic [1:0]  sel_idx;
    logic        unused_sel;

    assign unused_sel = ^sel[7:4];

    btn_edge u_up_edge (
        .clk    (clk),
        .resetn (resetn),
        .btn    (up),
        .rise   (up_rise)
    );

    btn_edge u_dn_edge (
        .clk    (clk),
        .resetn (resetn),
        .btn    (down),
        .rise   (dn_rise)
    );

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (sel[3:0])
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

`ifdef TIME_EDITOR_AUTOREPEAT_EN
    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_fire;

    // Counts cycles since the edge of the single held button; after the first repeat
    // the count is rewound so the next match lands REPEAT_RATE cycles later.
    always_comb begin
        rpt_cnt_d = '0;
        rpt_fire  = 1'b0;
        if (state_q == ST_EDIT && (up ^ down)) begin
            if (up_rise | dn_rise) begin
                rpt_cnt_d = CNT_W'(1);
            end else if (rpt_cnt_q == CNT_W'(REPEAT_DELAY)) begin
                rpt_fire  = 1'b1;
                rpt_cnt_d = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rpt_cnt_q <= '0;
        else
            rpt_cnt_q <= rpt_cnt_d;
    end

    assign up_rpt = rpt_fire & up;
    assign dn_rpt = rpt_fire & down;
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;

    assign up_rpt = 1'b0;
    assign dn_rpt = 1'b0;
`endif

    assign up_req = up_rise | up_rpt;
    assign dn_req = dn_rise | dn_rpt;

    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    edit_d  = time_in;
                    state_d = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (!active)
                    state_d = ST_COMMIT;
                else if (sel_ok && (up_req ^ dn_req))
                    edit_d = step_time(edit_q, sel_idx, up_req);
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            edit_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            edit_q  <= edit_d;
        end
    end

    assign edit_time = edit_q;
    assign editing   = (state_q == ST_EDIT);
    assign commit    = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_time_editor.sv
// Directed bench for time_editor: expected outputs are queued as stimulus is driven and
// compared once the DUT has had its clock edge.
module tb_time_editor;

    logic        clk;
    logic        resetn;
    logic        active;
    logic [7:0]  sel;
    logic        up;
    logic        down;
    logic [15:0] time_in;
    logic [15:0] edit_time;
    logic        editing;
    logic        commit;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [15:0] t;
        logic        ed;
        logic        cm;
    } exp_t;

    exp_t sb[$];

    time_editor #(
        .REPEAT_DELAY (32),
        .REPEAT_RATE  (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .active    (active),
        .sel       (sel),
        .up        (up),
        .down      (down),
        .time_in   (time_in),
        .edit_time (edit_time),
        .editing   (editing),
        .commit    (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] t, input logic ed, input logic cm);
        exp_t e;
        e.tag = tag;
        e.t   = t;
        e.ed  = ed;
        e.cm  = cm;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=nonzero");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (edit_time === e.t) else begin
                failures++;
                $error("FAIL %s edit_time observed=%h expected=%h", e.tag, edit_time, e.t);
            end
            checks++;
            assert (editing === e.ed) else begin
                failures++;
                $error("FAIL %s editing observed=%b expected=%b", e.tag, editing, e.ed);
            end
            checks++;
            assert (commit === e.cm) else begin
                failures++;
                $error("FAIL %s commit observed=%b expected=%b", e.tag, commit, e.cm);
            end
            $display("txn %-12s edit_time=%h editing=%b commit=%b", e.tag, edit_time, editing, commit);
        end
    endtask

    task automatic step(input string tag, input logic [15:0] t, input logic ed, input logic cm);
        push(tag, t, ed, cm);
        tick();
        pop_check();
    endtask

    // One-cycle press (u/d chosen) followed by one released cycle; value must hold after release.
    task automatic pulse(input string tag, input logic u, input logic d, input logic [15:0] t);
        up   = u;
        down = d;
        step(tag, t, 1'b1, 1'b0);
        up   = 1'b0;
        down = 1'b0;
        step({tag, "_rel"}, t, 1'b1, 1'b0);
    endtask

    logic [15:0] mu_exp [5];
    logic [15:0] mt_exp [4];
    logic [15:0] hold_exp;

    initial begin
        mu_exp = '{16'h1235, 16'h1236, 16'h1237, 16'h1238, 16'h1239};
        mt_exp = '{16'h1239, 16'h1249, 16'h1259, 16'h1209};
`ifdef TIME_EDITOR_AUTOREPEAT_EN
        hold_exp = 16'h0003;
`else
        hold_exp = 16'h0001;
`endif
        resetn  = 1'b0;
        active  = 1'b0;
        sel     = 8'h00;
        up      = 1'b0;
        down    = 1'b0;
        time_in = 16'h1234;
        tick();
        tick();
        push("reset", 16'h0000, 1'b0, 1'b0);
        pop_check();

        resetn = 1'b1;
        step("idle", 16'h0000, 1'b0, 1'b0);

        active = 1'b1;
        step("capture", 16'h1234, 1'b1, 1'b0);

        sel = 8'h01;
        for (int i = 0; i < 5; i++) pulse("mu_up", 1'b1, 1'b0, mu_exp[i]);
        pulse("mu_wrap_up", 1'b1, 1'b0, 16'h1230);
        pulse("mu_wrap_dn", 1'b0, 1'b1, 16'h1239);

        sel = 8'h02;
        pulse("mt_dn", 1'b0, 1'b1, 16'h1229);
        for (int i = 0; i < 4; i++) pulse("mt_up", 1'b1, 1'b0, mt_exp[i]);

        sel = 8'h03;
        pulse("multi_sel", 1'b1, 1'b0, 16'h1209);
        sel = 8'h00;
        pulse("no_sel", 1'b1, 1'b0, 16'h1209);
        sel = 8'h01;
        pulse("both_btn", 1'b1, 1'b1, 16'h1209);

        active = 1'b0;
        up     = 1'b1;
        step("commit", 16'h1209, 1'b0, 1'b1);
        up = 1'b0;
        step("back_idle", 16'h1209, 1'b0, 1'b0);

        up = 1'b1;
        step("idle_press", 16'h1209, 1'b0, 1'b0);
        time_in = 16'h1945;
        active  = 1'b1;
        step("recapture", 16'h1945, 1'b1, 1'b0);
        step("held_in", 16'h1945, 1'b1, 1'b0);
        up = 1'b0;
        step("held_rel", 16'h1945, 1'b1, 1'b0);

        sel = 8'h08;
        pulse("ht_clamp", 1'b1, 1'b0, 16'h2345);
        sel = 8'h04;
        pulse("hu_wrap20", 1'b1, 1'b0, 16'h2045);
        pulse("hu_dn20", 1'b0, 1'b1, 16'h2345);
        sel = 8'h08;
        pulse("ht_wrap_up", 1'b1, 1'b0, 16'h0345);
        pulse("ht_wrap_dn", 1'b0, 1'b1, 16'h2345);
        sel = 8'h11;
        pulse("sel_hi_ign", 1'b1, 1'b0, 16'h2346);

        resetn = 1'b0;
        active = 1'b0;
        #1;
        push("rst_async", 16'h0000, 1'b0, 1'b0);
        pop_check();
        step("rst_hold1", 16'h0000, 1'b0, 1'b0);
        step("rst_hold2", 16'h0000, 1'b0, 1'b0);

        time_in = 16'h0000;
        active  = 1'b1;
        sel     = 8'h01;
        resetn  = 1'b1;
        step("rst_capture", 16'h0000, 1'b1, 1'b0);

        push("hold48", hold_exp, 1'b1, 1'b0);
        up = 1'b1;
        repeat (48) tick();
        up = 1'b0;
        tick();
        pop_check();

        active = 1'b0;
        step("commit2", hold_exp, 1'b0, 1'b1);
        step("idle2", hold_exp, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
